fifo_stream_reader: RTL and testbench
=====================================

Name: fifo_stream_reader

Overview:
Read-side controller that drains a sync_fifo-style buffer (rd_en/dout/empty, dout registered with 1-cycle read latency). It presents the data as a valid/ready stream to a downstream consumer. Read requests are credit-gated and backed by a 2-entry skid buffer, so no word is lost or duplicated when m_ready drops. It sits between the FIFO read port and any streaming sink.

Parameters:
DATA_WIDTH, 8, width of FIFO data and stream payload
CNT_WIDTH, 16, width of the optional delivered-word counter

Ports:
clk  input  1  single system clock, rising edge
rstn  input  1  asynchronous active-low reset
fifo_empty  input  1  FIFO empty flag
fifo_dout  input  DATA_WIDTH  FIFO registered read data; valid the cycle after a read is accepted
fifo_rd_en  output  1  FIFO read request
m_valid  output  1  stream data valid
m_ready  input  1  downstream accept
m_data  output  DATA_WIDTH  stream payload
word_cnt  output  CNT_WIDTH  words delivered (present only with FIFO_READER_CNT_EN)

Behaviour:
- Reset (rstn low, async): occupancy=0, rd_pending=0, skid entries cleared to 0, m_valid=0, m_data=0, word_cnt=0. fifo_rd_en is forced to 0 while rstn is low.
- State:
  - occ: 0..2, words held in the skid buffer.
  - rd_pending: 1 bit, set for the cycle after fifo_rd_en was high.
- pop = m_valid && m_ready.
- Issue rule (combinational): fifo_rd_en = !fifo_empty && (occ + rd_pending - pop) < 2. This guarantees a pending word always has a free slot.
- Capture: when rd_pending=1, fifo_dout is written into the skid buffer on that edge.
  - Simultaneous capture and pop: occ is unchanged; the captured word goes behind the remaining word, or to head if occ was 1.
  - Capture with no pop: occ+1. Pop with no capture: occ-1.
- Ordering: strict FIFO order. Head entry drives m_data. On pop, the second entry shifts to head.
- m_valid = (occ != 0), registered.
  - While m_valid=1 and m_ready=0, m_data and m_valid hold stable.
  - m_valid never deasserts without a pop.
- Latency: first fifo_rd_en high at edge E0 gives fifo_dout valid after E0, capture at E1, and m_valid high after E1. That is 2 edges from request to m_valid.
- Throughput: with m_ready held 1 and the FIFO non-empty, the block sustains 1 word/cycle (steady state occ=1, rd_pending=1).
- Boundaries:
  - fifo_empty=1: no request. The existing occ drains normally.
  - m_ready=0 for a long time: occ fills to 2, then fifo_rd_en stays 0. No overrun.
  - FIFO goes empty mid-burst: the in-flight word is still captured. Then there are no further requests.
  - m_ready toggled every cycle: no loss or duplication.
  - Reset mid-transfer: pending and buffered words are discarded. The FIFO shares rstn and clears too.
- Arithmetic: occ+rd_pending-pop is evaluated in 3-bit unsigned. The result is never negative, because pop implies occ>=1.

Optional Feature:
FIFO_READER_CNT_EN
- Defined: word_cnt port exists. It increments by 1 on each pop and wraps modulo 2^CNT_WIDTH. Reset value is 0.
- Undefined: no word_cnt port and no counter logic. All other behaviour is identical.

Decomposition:
- Package fifo_pkg holds:
  - localparam FIFO_DATA_WIDTH = 8.
  - typedef logic [1:0] skid_occ_t.
  - localparam SKID_DEPTH = 2.
- One natural sub-module: fifo_skid_buf. It is a 2-entry in-order buffer with push/pop/occ/head_data. fifo_stream_reader keeps the issue/credit logic and the optional counter.

Test Plan:
- Single word (reset, FIFO preloaded with 0xA5, m_ready=1) -> exactly one fifo_rd_en pulse; m_valid high for 1 cycle 2 edges later with m_data=0xA5; then m_valid=0.
- Burst (16 words 0x00..0x0F preloaded, m_ready=1) -> 16 consecutive m_valid cycles in order with no gaps after the initial 2-edge latency; fifo_rd_en asserted 16 cycles total.
- Backpressure (16 words, m_ready=0 for 10 cycles then 1) -> at most 2 fifo_rd_en pulses during the stall; m_data=0x00 held stable; on release all 16 words appear in order, none lost or duplicated.
- Alternating m_ready (1,0,1,0...) with 8 words 0x10..0x17 -> the 8 words delivered in order; m_data is stable across every stalled cycle.
- Reset mid-burst (assert rstn low after 5 of 16 words) -> m_valid=0, m_data=0, fifo_rd_en=0 immediately; after release with empty FIFO there are no requests.
- With FIFO_READER_CNT_EN, CNT_WIDTH=4, 18 words -> word_cnt wraps 15→0 and reads 2 at the end; without the macro the bench compiles with no word_cnt port.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO stream reader and its skid buffer.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int SKID_DEPTH      = 2;

    typedef logic [1:0] skid_occ_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order skid buffer: entry 0 is the head and drives head_data.
// A simultaneous push and pop keeps the occupancy; the pushed word lands
// behind the surviving word, or at the head when only one word was held.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output skid_occ_t             occ,
    output logic [DATA_WIDTH-1:0] head_data
);

    skid_occ_t             occ_q, occ_d;
    logic [DATA_WIDTH-1:0] e0_q, e0_d;
    logic [DATA_WIDTH-1:0] e1_q, e1_d;

    // Next-state for the two entries and the occupancy count.
    always_comb begin
        occ_d = occ_q;
        e0_d  = e0_q;
        e1_d  = e1_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    e0_d = push_data;
                end else begin
                    e1_d = push_data;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                e1_d  = '0;
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd2) begin
                    e0_d = e1_q;
                    e1_d = push_data;
                end else begin
                    e0_d = push_data;
                end
            end
            default: ;
        endcase
    end

    // Entry and occupancy registers, cleared on async reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            occ_q <= '0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            occ_q <= occ_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
        end
    end

    assign occ       = occ_q;
    assign head_data = e0_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a 1-cycle-latency FIFO read port into a valid/ready stream.
// Reads are only issued when the skid buffer is guaranteed a free slot for
// the returning word, so backpressure never loses or duplicates data.
// Optional delivered-word counter enabled by defining FIFO_READER_CNT_EN.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_READER_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  word_cnt
`endif
);

    skid_occ_t  occ;
    logic       pop;
    logic       rd_pending_q, rd_pending_d;
    logic [2:0] credit_sum;

    assign m_valid = (occ != 2'd0);
    assign pop     = m_valid && m_ready;

    // Read issue: words held plus word in flight, minus the one leaving,
    // must stay below the buffer depth. pop implies occ>=1, so no underflow.
    always_comb begin
        credit_sum   = {1'b0, occ} + {2'b00, rd_pending_q} - {2'b00, pop};
        fifo_rd_en   = rstn && !fifo_empty && (credit_sum < 3'(SKID_DEPTH));
        rd_pending_d = fifo_rd_en;
    end

    // Tracks that fifo_dout carries a fresh word on the coming edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_pending_q <= 1'b0;
        end else begin
            rd_pending_q <= rd_pending_d;
        end
    end

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rstn      (rstn),
        .push      (rd_pending_q),
        .push_data (fifo_dout),
        .pop       (pop),
        .occ       (occ),
        .head_data (m_data)
    );

`ifdef FIFO_READER_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Delivered-word count, wrapping naturally at the counter width.
    always_comb begin
        cnt_d = cnt_q;
        if (pop) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign word_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader with a behavioural 1-cycle FIFO.
module tb_fifo_stream_reader;

    localparam int DW = 8;
`ifdef FIFO_READER_CNT_EN
    localparam int CW = 4;
`else
    localparam int CW = 16;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_dout  = '0;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
`ifdef FIFO_READER_CNT_EN
    logic [CW-1:0] word_cnt;
    logic [CW-1:0] prev_cnt = '0;
    bit            saw_wrap = 1'b0;
`endif

    fifo_stream_reader #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
`ifdef FIFO_READER_CNT_EN
        ,
        .word_cnt   (word_cnt)
`endif
    );

    initial forever #5 clk = ~clk;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rd_cnt, valid_cnt, delivered, first_rd, first_valid, last_valid;
    bit            stall_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural FIFO: registered dout, cleared by the shared reset.
    always @(negedge rstn) fq.delete();
    always @(posedge clk) begin
        cyc++;
        if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
        fifo_empty <= (fq.size() == 0);
    end

    // Monitor: scoreboard compare on every handshake, plus stall stability.
    always @(negedge clk) begin
        if (rstn) begin
            if (fifo_rd_en) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (m_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = cyc;
                last_valid = cyc;
            end
            if (stall_prev) begin
                check("stall_valid", {31'd0, m_valid}, 32'd1);
                check("stall_data", {24'd0, m_data}, {24'd0, stall_data});
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {24'd0, m_data}, 32'hFFFF_FFFF);
                end else begin
                    check("stream_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
                end
                delivered++;
            end
            stall_prev = m_valid && !m_ready;
            stall_data = m_data;
`ifdef FIFO_READER_CNT_EN
            if (prev_cnt == 4'hF && word_cnt == 4'h0) saw_wrap = 1'b1;
            prev_cnt = word_cnt;
`endif
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic clr();
        rd_cnt = 0; valid_cnt = 0; delivered = 0;
        first_rd = -1; first_valid = -1; last_valid = -1;
    endtask

    task automatic preload(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            fq.push_back(base + DW'(i));
            exp_q.push_back(base + DW'(i));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) check(name, 32'd0, 32'd1);
        repeat (2) step();
    endtask

    initial begin
        rstn = 1'b0;
        m_ready = 1'b0;
        clr();
        repeat (2) step();
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_data", {24'd0, m_data}, 32'd0);
        preload(1, 8'hA5);
        repeat (2) step();
        check("rst_rd_en_forced", {31'd0, fifo_rd_en}, 32'd0);

        // single word
        m_ready = 1'b1;
        clr();
        rstn = 1'b1;
        wait_drain("single_timeout", 30);
        check("single_rd_pulses", rd_cnt, 32'd1);
        check("single_latency", first_valid - first_rd, 32'd2);
        check("single_valid_cycles", valid_cnt, 32'd1);
        check("single_delivered", delivered, 32'd1);

        // burst of 16 at full rate
        clr();
        preload(16, 8'h00);
        wait_drain("burst_timeout", 60);
        check("burst_rd_cycles", rd_cnt, 32'd16);
        check("burst_valid_cycles", valid_cnt, 32'd16);
        check("burst_no_gaps", last_valid - first_valid + 1, 32'd16);
        check("burst_latency", first_valid - first_rd, 32'd2);

        // backpressure: 10 stalled cycles, then release
        clr();
        m_ready = 1'b0;
        preload(16, 8'h00);
        repeat (10) step();
        check("stall_rd_bound", {31'd0, rd_cnt <= 2}, 32'd1);
        check("stall_head_valid", {31'd0, m_valid}, 32'd1);
        check("stall_head_data", {24'd0, m_data}, 32'h00);
        m_ready = 1'b1;
        wait_drain("bp_timeout", 80);
        check("bp_delivered", delivered, 32'd16);

        // alternating ready
        clr();
        preload(8, 8'h10);
        for (int i = 0; i < 80 && (exp_q.size() != 0 || m_valid); i++) begin
            m_ready = (i % 2 == 0);
            step();
        end
        m_ready = 1'b1;
        wait_drain("alt_timeout", 10);
        check("alt_delivered", delivered, 32'd8);

        // reset after 5 of 16 words
        clr();
        preload(16, 8'h20);
        for (int i = 0; i < 50 && delivered < 5; i++) step();
        check("mid_reached5", delivered, 32'd5);
        rstn = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, m_valid}, 32'd0);
        check("mid_rst_data", {24'd0, m_data}, 32'd0);
        check("mid_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        exp_q.delete();
        repeat (2) step();
        clr();
        rstn = 1'b1;
        repeat (6) step();
        check("post_rst_no_req", rd_cnt, 32'd0);
        check("post_rst_no_valid", valid_cnt, 32'd0);

`ifdef FIFO_READER_CNT_EN
        // counter wrap with 4-bit width
        clr();
        preload(18, 8'h40);
        wait_drain("cnt_timeout", 80);
        check("cnt_delivered", delivered, 32'd18);
        check("cnt_wrapped", {31'd0, saw_wrap}, 32'd1);
        check("cnt_final", {28'd0, word_cnt}, 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
